// File: rtl/mem_wb_if.sv
// MEM -> WB stage bus: result fields plus the valid/allowin handshake.
// Handshake: a transfer happens on a clk edge where mem_wb_valid & wb_allowin are both 1.
interface mem_wb_if #(
    parameter int XLEN          = 32,
    parameter int RF_ADDR_WIDTH = 5
);
    logic                     wb_allowin;
    logic                     mem_wb_valid;
    logic                     wb_valid;
    logic [XLEN-1:0]          wb_pc;
    logic [XLEN-1:0]          wb_inst;
    logic                     wb_req_rf;
    logic [RF_ADDR_WIDTH-1:0] wb_rf_waddr;
    logic [XLEN-1:0]          wb_rf_wdata;
    logic                     wb_load_misal;
    logic                     wb_exp_flag;
    logic                     wb_int_flag;
    logic                     wb_inst_addr_misal;
    logic                     wb_is_illg_inst;
    logic                     wb_is_ecall_inst;
    logic                     wb_is_ebreak_inst;

    modport master (
        input  wb_allowin,
        output mem_wb_valid, wb_valid, wb_pc, wb_inst, wb_req_rf, wb_rf_waddr,
               wb_rf_wdata, wb_load_misal, wb_exp_flag, wb_int_flag,
               wb_inst_addr_misal, wb_is_illg_inst, wb_is_ecall_inst, wb_is_ebreak_inst
    );

    modport slave (
        output wb_allowin,
        input  mem_wb_valid, wb_valid, wb_pc, wb_inst, wb_req_rf, wb_rf_waddr,
               wb_rf_wdata, wb_load_misal, wb_exp_flag, wb_int_flag,
               wb_inst_addr_misal, wb_is_illg_inst, wb_is_ecall_inst, wb_is_ebreak_inst
    );
endinterface

// File: rtl/mem_wb.sv
// Memory stage controller and MEM/WB register: waits for load data, extracts and
// extends it, flags misaligned loads and discards responses of flushed loads.
module mem_wb #(
    parameter int XLEN          = 32,
    parameter int RF_ADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_flush,
    input  logic                     ex_mem_valid,
    output logic                     mem_allowin,
    output logic                     mem_valid,
    input  logic [XLEN-1:0]          mem_pc,
    input  logic [XLEN-1:0]          mem_inst,
    input  logic                     mem_req_rf,
    input  logic [RF_ADDR_WIDTH-1:0] mem_rf_waddr,
    input  logic [XLEN-1:0]          mem_alu_res,
    input  logic                     mem_is_load,
    input  logic [1:0]               mem_ls_addr_2low,
    input  logic [4:0]               mem_l_mask,
    input  logic                     ex2mem_exp_flag,
    input  logic                     ex2mem_int_flag,
    input  logic                     ex2mem_inst_addr_misal,
    input  logic                     ex2mem_is_illg_inst,
    input  logic                     ex2mem_is_ecall_inst,
    input  logic                     ex2mem_is_ebreak_inst,
    input  logic                     dmem_rvalid,
    input  logic [XLEN-1:0]          dmem_rdata,
    mem_wb_if.master                 wb,
    output logic [1:0]               dbg_state,
    output logic                     dbg_drop
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HAVE = 2'd2} state_t;

    state_t          state, state_nxt;
    logic [1:0]      drop_cnt, drop_nxt;
    logic [XLEN-1:0] ld_buf, buf_nxt;
    logic            misal, aligned_load, usable_rvalid, mem_ready_go, pending;
    logic [2:0]      outstanding;
    logic [XLEN-1:0] ld_word, ld_data, res_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    assign misal = mem_is_load &
                   ((mem_l_mask[4] & (mem_ls_addr_2low != 2'b00)) |
                    ((mem_l_mask[2] | mem_l_mask[3]) & mem_ls_addr_2low[0]));
    assign aligned_load  = mem_valid & mem_is_load & ~misal;
    assign usable_rvalid = dmem_rvalid & (drop_cnt == 2'd0);
    assign mem_ready_go  = ~mem_is_load | misal | (state == S_HAVE) | usable_rvalid;
    assign wb.mem_wb_valid = mem_valid & mem_ready_go;
    assign mem_allowin   = ~mem_valid | (mem_ready_go & wb.wb_allowin);

    // drop counts responses still owed to killed loads; a count rather than a
    // flag so a load waiting behind a stale response survives a second flush.
    assign pending     = (state == S_WAIT) | ((state == S_IDLE) & aligned_load);
    assign outstanding = {1'b0, drop_cnt} + {2'b00, pending};

    always_comb begin
        state_nxt = state;
        buf_nxt   = ld_buf;
        drop_nxt  = drop_cnt;
        if (pipe_flush) begin
            state_nxt = S_IDLE;
            buf_nxt   = '0;
            if (dmem_rvalid && outstanding != 3'd0) drop_nxt = 2'(outstanding - 3'd1);
            else                                    drop_nxt = outstanding[1:0];
        end else begin
            if (drop_cnt != 2'd0 && dmem_rvalid) drop_nxt = drop_cnt - 2'd1;
            case (state)
                S_IDLE: if (aligned_load) begin
                    if (!usable_rvalid) state_nxt = S_WAIT;
                    else if (!wb.wb_allowin) begin
                        state_nxt = S_HAVE;
                        buf_nxt   = dmem_rdata;
                    end
                end
                S_WAIT: if (usable_rvalid) begin
                    if (wb.wb_allowin) state_nxt = S_IDLE;
                    else begin
                        state_nxt = S_HAVE;
                        buf_nxt   = dmem_rdata;
                    end
                end
                S_HAVE: if (wb.mem_wb_valid && wb.wb_allowin) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            drop_cnt <= 2'd0;
            ld_buf   <= '0;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_nxt;
            ld_buf   <= buf_nxt;
        end
    end

    assign ld_word = (state == S_HAVE) ? ld_buf : dmem_rdata;
    assign ld_half = mem_ls_addr_2low[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        case (mem_ls_addr_2low)
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            2'd3:    ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
    end

    always_comb begin
        ld_data = ld_word;
        if      (mem_l_mask[0]) ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
        else if (mem_l_mask[1]) ld_data = {{(XLEN-8){1'b0}}, ld_byte};
        else if (mem_l_mask[2]) ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
        else if (mem_l_mask[3]) ld_data = {{(XLEN-16){1'b0}}, ld_half};
    end

    // A misaligned load carries its faulting address in the data field.
    assign res_data = (mem_is_load & ~misal) ? ld_data : mem_alu_res;

    always_ff @(posedge clk) begin
        if (!rst_n)          mem_valid <= 1'b0;
        else if (pipe_flush) mem_valid <= 1'b0;
        else if (mem_allowin) mem_valid <= ex_mem_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb.wb_valid           <= 1'b0;
            wb.wb_pc              <= '0;
            wb.wb_inst            <= '0;
            wb.wb_req_rf          <= 1'b0;
            wb.wb_rf_waddr        <= '0;
            wb.wb_rf_wdata        <= '0;
            wb.wb_load_misal      <= 1'b0;
            wb.wb_exp_flag        <= 1'b0;
            wb.wb_int_flag        <= 1'b0;
            wb.wb_inst_addr_misal <= 1'b0;
            wb.wb_is_illg_inst    <= 1'b0;
            wb.wb_is_ecall_inst   <= 1'b0;
            wb.wb_is_ebreak_inst  <= 1'b0;
        end else if (pipe_flush) begin
            wb.wb_valid  <= 1'b0;
            wb.wb_req_rf <= 1'b0;
        end else if (wb.mem_wb_valid && wb.wb_allowin) begin
            wb.wb_valid           <= 1'b1;
            wb.wb_pc              <= mem_pc;
            wb.wb_inst            <= mem_inst;
            wb.wb_req_rf          <= mem_req_rf & ~misal;
            wb.wb_rf_waddr        <= mem_rf_waddr;
            wb.wb_rf_wdata        <= res_data;
            wb.wb_load_misal      <= misal;
            wb.wb_exp_flag        <= ex2mem_exp_flag;
            wb.wb_int_flag        <= ex2mem_int_flag;
            wb.wb_inst_addr_misal <= ex2mem_inst_addr_misal;
            wb.wb_is_illg_inst    <= ex2mem_is_illg_inst;
            wb.wb_is_ecall_inst   <= ex2mem_is_ecall_inst;
            wb.wb_is_ebreak_inst  <= ex2mem_is_ebreak_inst;
        end else if (wb.wb_allowin) begin
            wb.wb_valid <= 1'b0;
        end
    end

    assign dbg_state = state;
    assign dbg_drop  = (drop_cnt != 2'd0);
endmodule

// File: tb/tb_mem_wb.sv
// Bench for mem_wb: directed scenarios then randomized traffic, with a memory
// model, a scoreboard of expected WB results and a monitor on the WB bus.
module tb_mem_wb;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int EW   = 109;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        req_rf;
        logic [4:0]  waddr;
        logic        is_load;
        logic [1:0]  a2;
        logic [4:0]  mask;
        logic [5:0]  flags;
    } instr_t;

    logic clk = 1'b0;
    logic rst_n, pipe_flush, ex_mem_valid, mem_allowin, mem_valid;
    logic [31:0] mem_pc, mem_inst, mem_alu_res, dmem_rdata;
    logic mem_req_rf, mem_is_load, dmem_rvalid;
    logic [AW-1:0] mem_rf_waddr;
    logic [1:0] mem_ls_addr_2low, dbg_state;
    logic [4:0] mem_l_mask;
    logic [5:0] fl;
    logic dbg_drop;

    mem_wb_if #(.XLEN(XLEN), .RF_ADDR_WIDTH(AW)) wb_bus ();

    mem_wb #(.XLEN(XLEN), .RF_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush), .ex_mem_valid(ex_mem_valid),
        .mem_allowin(mem_allowin), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_inst(mem_inst),
        .mem_req_rf(mem_req_rf), .mem_rf_waddr(mem_rf_waddr), .mem_alu_res(mem_alu_res),
        .mem_is_load(mem_is_load), .mem_ls_addr_2low(mem_ls_addr_2low), .mem_l_mask(mem_l_mask),
        .ex2mem_exp_flag(fl[5]), .ex2mem_int_flag(fl[4]), .ex2mem_inst_addr_misal(fl[3]),
        .ex2mem_is_illg_inst(fl[2]), .ex2mem_is_ecall_inst(fl[1]), .ex2mem_is_ebreak_inst(fl[0]),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb(wb_bus),
        .dbg_state(dbg_state), .dbg_drop(dbg_drop)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, wb_seen = 0;
    logic [EW-1:0] exp_q[$];
    logic [31:0]   resp_q[$];
    int resp_cnt = 0, lat_fix = -1, lat_max = 3;
    logic rst_now = 1'b0, flush_now = 1'b0, allow_now = 1'b1, ex_v = 1'b0, last_allowin;
    instr_t nxt, cur;
    logic [31:0] pc_ctr = 32'h1000;

    // ---------------- reference model ----------------
    function automatic logic misal_of(instr_t i);
        if (!i.is_load) return 1'b0;
        if (i.mask == 5'b10000) return i.a2 != 0;
        if (i.mask == 5'b00100 || i.mask == 5'b01000) return (i.a2 % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_value(instr_t i);
        int unsigned w, b, h;
        w = i.rdata;
        b = (w >> (8 * i.a2)) & 32'hFF;
        h = (w >> (16 * (i.a2 / 2))) & 32'hFFFF;
        case (i.mask)
            5'b00001: return (b >= 128) ? b - 256 : b;
            5'b00010: return b;
            5'b00100: return (h >= 32768) ? h - 65536 : h;
            5'b01000: return h;
            default:  return w;
        endcase
    endfunction

    function automatic logic [EW-1:0] exp_of(instr_t i);
        logic m;
        logic [31:0] d;
        m = misal_of(i);
        d = m ? 32'd0 : (i.is_load ? load_value(i) : i.alu);
        return {i.pc, i.inst, i.req_rf & !m, i.waddr, d, m, i.flags};
    endfunction

    function automatic instr_t gen_instr();
        instr_t i;
        i.pc      = pc_ctr;
        i.inst    = $urandom();
        i.alu     = $urandom();
        i.rdata   = $urandom();
        i.req_rf  = $urandom_range(0, 3) != 0;
        i.waddr   = 5'($urandom_range(0, 31));
        i.is_load = $urandom_range(0, 1) == 1;
        i.a2      = 2'($urandom_range(0, 3));
        i.mask    = 5'(1 << $urandom_range(0, 4));
        i.flags   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
        pc_ctr    = pc_ctr + 4;
        return i;
    endfunction

    function automatic instr_t mk_load(logic [4:0] mask, logic [1:0] a2, logic [31:0] data);
        instr_t i;
        i = gen_instr();
        i.is_load = 1'b1;
        i.req_rf  = 1'b1;
        i.mask    = mask;
        i.a2      = a2;
        i.rdata   = data;
        i.flags   = 6'd0;
        return i;
    endfunction

    function automatic int pick_lat();
        return (lat_fix >= 0) ? lat_fix : $urandom_range(0, lat_max);
    endfunction

    // ---------------- driver ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cycle();
        logic rv;
        @(negedge clk);
        rst_n        = rst_now;
        pipe_flush   = flush_now;
        wb_bus.wb_allowin = allow_now;
        ex_mem_valid = ex_v;
        mem_pc = cur.pc; mem_inst = cur.inst; mem_alu_res = cur.alu; mem_req_rf = cur.req_rf;
        mem_rf_waddr = cur.waddr; mem_is_load = cur.is_load; mem_ls_addr_2low = cur.a2;
        mem_l_mask = cur.mask; fl = cur.flags;
        rv = (resp_q.size() > 0) && (resp_cnt == 0);
        dmem_rvalid = rv;
        dmem_rdata  = rv ? resp_q[0] : $urandom();
        #4;
        last_allowin = mem_allowin;
        if (!rst_now) begin
            resp_q.delete();
            exp_q.delete();
            resp_cnt = 0;
        end else begin
            if (rv) begin
                void'(resp_q.pop_front());
                if (resp_q.size() > 0) resp_cnt = pick_lat();
            end else if (resp_q.size() > 0) begin
                resp_cnt--;
            end
            if (flush_now) exp_q.delete();
            else if (ex_v && mem_allowin) begin
                cur  = nxt;
                ex_v = 1'b0;
                exp_q.push_back(exp_of(nxt));
                if (nxt.is_load && !misal_of(nxt)) begin
                    resp_q.push_back(nxt.rdata);
                    if (resp_q.size() == 1) resp_cnt = pick_lat();
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic issue(input instr_t i);
        int n;
        nxt  = i;
        ex_v = 1'b1;
        n = 0;
        while (ex_v && n < 50) begin cycle(); n++; end
        if (ex_v) begin errors++; $display("FAIL issue_timeout: mem_allowin stuck low"); ex_v = 1'b0; end
    endtask

    task automatic drain(input string name);
        int n;
        flush_now = 1'b0;
        allow_now = 1'b1;
        n = 0;
        while ((exp_q.size() > 0 || resp_q.size() > 0) && n < 200) begin cycle(); n++; end
        repeat (3) cycle();
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic e_allow, e_rst, e_flush;
        logic [EW-1:0] got, exp;
        e_allow = wb_bus.wb_allowin;
        e_rst   = rst_n;
        e_flush = pipe_flush;
        #1;
        if (e_rst && e_flush) begin
            checks++;
            if (wb_bus.wb_valid !== 1'b0 || wb_bus.wb_req_rf !== 1'b0) begin
                errors++;
                $display("FAIL flush_wb: valid %b req_rf %b expected 0 0", wb_bus.wb_valid, wb_bus.wb_req_rf);
            end
        end else if (e_rst && e_allow && wb_bus.wb_valid === 1'b1) begin
            wb_seen++;
            got = {wb_bus.wb_pc, wb_bus.wb_inst, wb_bus.wb_req_rf, wb_bus.wb_rf_waddr,
                   wb_bus.wb_load_misal ? 32'd0 : wb_bus.wb_rf_wdata, wb_bus.wb_load_misal,
                   wb_bus.wb_exp_flag, wb_bus.wb_int_flag, wb_bus.wb_inst_addr_misal,
                   wb_bus.wb_is_illg_inst, wb_bus.wb_is_ecall_inst, wb_bus.wb_is_ebreak_inst};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got %h with nothing expected", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL wb_result: got %h expected %h", got, exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        instr_t t;
        int seen0;
        cur = gen_instr();
        nxt = cur;
        rst_now = 1'b0;
        repeat (3) cycle();
        rst_now = 1'b1;
        #1;
        check("rst_wb_valid", wb_bus.wb_valid, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_wb_req_rf", wb_bus.wb_req_rf, 0);
        check("rst_wb_wdata", wb_bus.wb_rf_wdata, 0);
        check("rst_state", dbg_state, 0);
        check("rst_drop", dbg_drop, 0);

        // 1: back-to-back ALU ops
        t = gen_instr(); t.is_load = 1'b0; t.alu = 32'h11; nxt = t; ex_v = 1'b1; cycle();
        t = gen_instr(); t.is_load = 1'b0; t.alu = 32'h22; nxt = t; ex_v = 1'b1; cycle();
        #1; check("alu1_valid", wb_bus.wb_valid, 1); check("alu1_data", wb_bus.wb_rf_wdata, 32'h11);
        cycle();
        #1; check("alu2_valid", wb_bus.wb_valid, 1); check("alu2_data", wb_bus.wb_rf_wdata, 32'h22);
        drain("t1");

        // 2: LB, response two cycles late
        lat_fix = 2;
        issue(mk_load(5'b00001, 2'd3, 32'h80FF_FF00));
        cycle(); check("lb_allowin_w1", last_allowin, 0);
        cycle(); check("lb_allowin_w2", last_allowin, 0);
        #1; check("lb_state_wait", dbg_state, 1);
        cycle();
        #1; check("lb_data", wb_bus.wb_rf_wdata, 32'hFFFF_FF80);
        drain("t2");

        // 3: LHU held in HAVE while WB stalls
        lat_fix = 1;
        seen0 = wb_seen;
        issue(mk_load(5'b01000, 2'd2, 32'h9ABC_1234));
        cycle();
        allow_now = 1'b0;
        cycle(); #1; check("lhu_state_have", dbg_state, 2);
        cycle(); cycle(); #1; check("lhu_state_hold", dbg_state, 2);
        allow_now = 1'b1;
        cycle(); #1; check("lhu_data", wb_bus.wb_rf_wdata, 32'h0000_9ABC);
        drain("t3");
        check("lhu_once", wb_seen - seen0, 1);

        // 4: misaligned LW
        issue(mk_load(5'b10000, 2'd1, 32'h5555_AAAA));
        cycle(); check("lwm_allowin", last_allowin, 1);
        #1; check("lwm_misal", wb_bus.wb_load_misal, 1); check("lwm_req_rf", wb_bus.wb_req_rf, 0);
        drain("t4");

        // 5: flush with a load in flight, stale response discarded
        lat_fix = 3;
        seen0 = wb_seen;
        issue(mk_load(5'b10000, 2'd0, 32'hDEAD_BEEF));
        cycle();
        flush_now = 1'b1; cycle(); flush_now = 1'b0;
        #1; check("fl_drop", dbg_drop, 1); check("fl_mem_valid", mem_valid, 0);
        lat_fix = 1;
        issue(mk_load(5'b10000, 2'd0, 32'h1234_5678));
        cycle(); cycle(); cycle();
        #1; check("fl_new_data", wb_bus.wb_rf_wdata, 32'h1234_5678);
        drain("t5");
        check("fl_once", wb_seen - seen0, 1);

        // 6: reset while waiting
        lat_fix = 3;
        issue(mk_load(5'b00100, 2'd2, 32'h8001_0002));
        cycle();
        rst_now = 1'b0; cycle(); rst_now = 1'b1;
        #1;
        check("rw_wb_valid", wb_bus.wb_valid, 0);
        check("rw_mem_valid", mem_valid, 0);
        check("rw_state", dbg_state, 0);
        check("rw_drop", dbg_drop, 0);
        cycle();

        // randomized traffic
        lat_fix = -1;
        for (int c = 0; c < 1500; c++) begin
            allow_now = $urandom_range(0, 3) != 0;
            if (!ex_v && $urandom_range(0, 3) != 0) begin nxt = gen_instr(); ex_v = 1'b1; end
            flush_now = ($urandom_range(0, 39) == 0) && (resp_q.size() <= 1);
            cycle();
        end
        ex_v = 1'b0;
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
